// File: rtl/mem_access_responder.sv
// mem_access_responder
// Memory-side responder for the multicycle controller. Takes one read or write
// request at a time, waits WAIT_CYCLES wait states, performs the access on an
// internal DEPTH x DATA_W array and pulses rsp_valid for one cycle. busy feeds
// the controller's stall/hold_decode path.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; request fields latched on accept
// WAIT   | wait states, counter runs WAIT_CYCLES..1
// ACCESS | array read/write (or range error) happens on the exit edge
// RESP   | one-cycle completion: rsp_valid=1, rsp_err=latched error
module mem_access_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata
);

    // Index width for the implemented words; a single-word array still needs one bit.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    // Range compare is done one bit wider so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                mem_we;

    // Array is deliberately not reset; contents survive a reset pulse.
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    assign accept   = (state == S_IDLE) && req_valid;
    assign in_range = ({1'b0, addr_q} < DEPTH_CMP);
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_we   = (state == S_ACCESS) && write_q && in_range;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; WAIT is skipped entirely when there are no wait states.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        rsp_valid = (state == S_RESP);
        rsp_err   = (state == S_RESP) && err_q;
        rsp_rdata = rdata_q;
    end

    // Wait-state down-counter, loaded on accept and decremented through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= WAIT_INIT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request capture; later changes on req_* are ignored until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Completion status and read data; writes leave rsp_rdata untouched and an
    // out-of-range read returns zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (state == S_ACCESS) begin
            err_q <= ~in_range;
            if (!write_q) begin
                rdata_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Array write port; only the ACCESS exit edge can modify memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_access_responder.sv
// Bench for mem_access_responder: three instances (W=2/DEPTH=200, W=0, W=15)
// driven from a vector table plus hand sequences; responses are checked by a
// per-instance scoreboard of expected completion cycle, error and read data.
module tb_mem_access_responder;

    typedef struct packed {
        logic [1:0]  unit;
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
    } vec_t;

    typedef struct packed {
        int          due;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    localparam int NV = 18;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [7:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic [2:0]  req_ready;
    logic [2:0]  busy;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic [15:0] rsp_rdata [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   waits [3] = '{2, 0, 15};
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];
    vec_t vecs [NV];

    mem_access_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .busy(busy[0]), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]),
        .rsp_rdata(rsp_rdata[0]));

    mem_access_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .busy(busy[1]), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]),
        .rsp_rdata(rsp_rdata[1]));

    mem_access_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(15)) dut_c (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
        .busy(busy[2]), .rsp_valid(rsp_valid[2]), .rsp_err(rsp_err[2]),
        .rsp_rdata(rsp_rdata[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sb_size(input int u);
        case (u)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_push(input int u, input exp_t e);
        case (u)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rsp(input int u, input exp_t e);
        checks++;
        if (cyc != e.due) begin
            errors++;
            $display("FAIL latency u%0d: rsp_valid at cycle %0d expected %0d", u, cyc, e.due);
        end
        checks++;
        if (rsp_err[u] !== e.err) begin
            errors++;
            $display("FAIL rsp_err u%0d: got %0b expected %0b", u, rsp_err[u], e.err);
        end
        checks++;
        if (rsp_rdata[u] !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata u%0d: got %04h expected %04h", u, rsp_rdata[u], e.rdata);
        end
    endtask

    task automatic unexpected(input int u);
        checks++;
        errors++;
        $display("FAIL spurious rsp u%0d: rsp_valid=1 at cycle %0d with nothing outstanding", u, cyc);
    endtask

    // Response monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int u = 0; u < 3; u++) begin
                if (rsp_valid[u]) begin
                    if (sb_size(u) == 0) begin
                        unexpected(u);
                    end else begin
                        case (u)
                            0:       check_rsp(0, sb0.pop_front());
                            1:       check_rsp(1, sb1.pop_front());
                            default: check_rsp(2, sb2.pop_front());
                        endcase
                    end
                end else if (rsp_err[u] !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_err idle u%0d: got 1 expected 0 outside completion", u);
                end
                if (busy[u] === req_ready[u]) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_vs_ready u%0d: busy=%0b req_ready=%0b", u, busy[u], req_ready[u]);
                end
            end
        end
    end

    // Issues one request once the unit is idle and records the expected completion.
    task automatic do_req(input int u, input logic w, input logic [7:0] a,
                          input logic [15:0] d, input logic e_err, input logic [15:0] e_rd);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout u%0d: req_ready=0 expected 1", u);
            return;
        end
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        e.due   = cyc + waits[u] + 2;
        e.err   = e_err;
        e.rdata = e_rd;
        sb_push(u, e);
        @(negedge clk);
        req_valid[u] = 1'b0;
        check_bit("busy_after_accept", busy[u], 1'b1);
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (sb_size(u) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_size(u) > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout u%0d: %0d responses outstanding expected 0", u, sb_size(u));
        end
    endtask

    initial begin
        int k;
        exp_t e;

        // unit, wr, addr, wdata, err, rdata
        vecs[0]  = '{2'd0, 1'b1, 8'h00, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{2'd0, 1'b1, 8'h10, 16'h00A5, 1'b0, 16'h0000};
        vecs[2]  = '{2'd0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h00A5};
        vecs[3]  = '{2'd0, 1'b1, 8'hC8, 16'hFFFF, 1'b1, 16'h00A5};
        vecs[4]  = '{2'd0, 1'b0, 8'hC8, 16'h0000, 1'b1, 16'h0000};
        vecs[5]  = '{2'd0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF};
        vecs[6]  = '{2'd0, 1'b1, 8'hC7, 16'h5A5A, 1'b0, 16'hBEEF};
        vecs[7]  = '{2'd0, 1'b0, 8'hC7, 16'h0000, 1'b0, 16'h5A5A};
        vecs[8]  = '{2'd0, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h0000};
        vecs[9]  = '{2'd0, 1'b1, 8'h01, 16'h1111, 1'b0, 16'h0000};
        vecs[10] = '{2'd0, 1'b1, 8'h02, 16'h2222, 1'b0, 16'h0000};
        vecs[11] = '{2'd1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h0000};
        vecs[12] = '{2'd1, 1'b1, 8'h03, 16'hCAFE, 1'b0, 16'h0000};
        vecs[13] = '{2'd1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'hCAFE};
        vecs[14] = '{2'd1, 1'b1, 8'hFF, 16'h0F0F, 1'b0, 16'hCAFE};
        vecs[15] = '{2'd1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0F0F};
        vecs[16] = '{2'd2, 1'b1, 8'h40, 16'h7777, 1'b0, 16'h0000};
        vecs[17] = '{2'd2, 1'b0, 8'h40, 16'h0000, 1'b0, 16'h7777};

        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        for (int u = 0; u < 3; u++) begin
            req_addr[u]  = '0;
            req_wdata[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check_bit("reset_req_ready", req_ready[u], 1'b1);
            check_bit("reset_busy", busy[u], 1'b0);
            check_bit("reset_rsp_valid", rsp_valid[u], 1'b0);
            checks++;
            if (rsp_rdata[u] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rdata u%0d: got %04h expected 0000", u, rsp_rdata[u]);
            end
        end
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_req(int'(vecs[i].unit), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].err, vecs[i].rdata);
            drain(int'(vecs[i].unit));
        end

        // Busy window of a W=2 read: high for the four cycles after accept only.
        @(negedge clk);
        k = cyc;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 8'h10;
        e = '{k + 4, 1'b0, 16'h00A5};
        sb0.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[0] = 1'b0;
            check_bit("busy_window", busy[0], 1'b1);
        end
        @(negedge clk);
        check_bit("busy_after_resp", busy[0], 1'b0);
        drain(0);

        // req_valid held for ten cycles with the address changing while busy.
        @(negedge clk);
        k = cyc;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 8'h01;
        e = '{k + 4, 1'b0, 16'h1111};
        sb0.push_back(e);
        e = '{k + 9, 1'b0, 16'h2222};
        sb0.push_back(e);
        repeat (2) @(negedge clk);
        req_addr[0] = 8'h02;
        repeat (8) @(negedge clk);
        req_valid[0] = 1'b0;
        drain(0);
        repeat (6) @(negedge clk);

        // Reset while a write sits in WAIT: request dropped, nothing written.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h20;
        req_wdata[0] = 16'h1234;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_bit("async_reset_ready", req_ready[0], 1'b1);
        check_bit("async_reset_busy", busy[0], 1'b0);
        check_bit("async_reset_rsp_valid", rsp_valid[0], 1'b0);
        check_bit("async_reset_rsp_err", rsp_err[0], 1'b0);
        checks++;
        if (rsp_rdata[0] !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_rdata: got %04h expected 0000", rsp_rdata[0]);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        do_req(0, 1'b0, 8'h20, 16'h0000, 1'b0, 16'h0000);
        drain(0);
        do_req(0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h00A5);
        drain(0);

        repeat (4) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (sb_size(u) != 0) begin
                errors++;
                $display("FAIL leftover u%0d: %0d outstanding expected 0", u, sb_size(u));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
